ex_extgen_pipe: RTL and testbench
=================================

Name: ex_extgen_pipe

Overview:
- Parametrised execute-stage result extension unit with a registered output.
- Takes a raw ALU or load result and produces a sign-extended or zero-extended byte, half or word, a pass-through value, or zero, selected by an op mode.
- Buffers results in a 2-entry skid FIFO with valid/ready handshakes on both sides, so the EX→MEM boundary can stall without losing data.
- Replaces the single-mode, combinational word sign-extender in the EX stage.

Parameters:
- DATA_W, 64: datapath width; legal values 32 or 64.
- TAG_W, 5: sideband tag (e.g. rd index) carried alongside the data unchanged.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- flush_i  input  1  synchronous pipeline flush; drops all buffered entries.
- in_valid_i  input  1  input beat valid.
- in_ready_o  output  1  unit can accept a beat this cycle.
- in_mode_i  input  3  extension mode (encoding under Behaviour).
- in_data_i  input  DATA_W  raw source value.
- in_tag_i  input  TAG_W  sideband tag.
- out_valid_o  output  1  head entry valid.
- out_ready_i  input  1  consumer accepts the head entry.
- out_data_o  output  DATA_W  extended result (head entry).
- out_tag_o  output  TAG_W  tag of the head entry.
- occupancy_o  output  2  buffered entry count, 0..2.

Behaviour:
- Mode encoding:
  - 000: pass in_data unchanged.
  - 001: sign-extend bits [7:0] (SB).
  - 010: sign-extend bits [15:0] (SH).
  - 011: sign-extend bits [31:0] (SW).
  - 100: output all-zero.
  - 101: zero-extend bits [7:0] (ZB).
  - 110: zero-extend bits [15:0] (ZH).
  - 111: zero-extend bits [31:0] (ZW).
- Width rule: when DATA_W=32, modes 011 and 111 both equal pass-through.
- Extension is computed combinationally on the input. The FIFO stores the already-extended data plus the tag; out_data_o is driven straight from FIFO storage, with no logic after the register.
- Push occurs when in_valid_i && in_ready_o && !flush_i.
- Pop occurs when out_valid_o && out_ready_i && !flush_i.
- in_ready_o = (occupancy != 2), decoded from registers only; no combinational path from out_ready_i.
- out_valid_o = (occupancy != 0).
- Latency: a beat accepted at edge N is visible on out_* after edge N (1 cycle) if the FIFO was empty.
- Ordering: strict FIFO order is preserved.
- Occupancy update:
  - Push only: occupancy +1.
  - Pop only: occupancy −1.
  - Push and pop in the same cycle: occupancy unchanged; the head advances and the new beat is written behind the remaining entry.
- Full (occupancy 2): in_ready_o=0, so no push is possible. A pop that cycle drops occupancy to 1, and in_ready_o=1 next cycle.
- Empty: a pop cannot occur (out_valid_o=0); out_data_o holds its last value.
- Storage: 2-entry circular buffer with a 1-bit read pointer and a 1-bit write pointer. Both wrap modulo 2.
- Flush: has priority over push and pop. At the next edge occupancy=0, pointers=0 and out_valid_o=0. A beat presented in the flush cycle is discarded.
- Reset (async, on rst rising):
  - occupancy=0, pointers=0.
  - out_valid_o=0, in_ready_o=1.
  - Storage cleared, so out_data_o=0 and out_tag_o=0.
- Reset mid-operation drops all in-flight entries immediately. No output glitches to valid=1 while rst is high.
- Consumer must not need out_data_o to be stable while out_valid_o=0.

Decomposition:
- Shared definitions (in the existing defines include):
  - the EXT_MODE_* 3-bit codes;
  - the DATA_W default of 64;
  - the zero-dword constant.
- One natural sub-module, ex_extgen_core:
  - purely combinational mode→extended-data function, parametrised by DATA_W;
  - instantiated once at the FIFO input.
- FIFO control and storage stay in the top module.

Test Plan:
- SW sign-extend with idle consumer: DATA_W=64, mode 011, data 0x0000_0000_8000_0001, tag 7, out_ready=1 → one cycle later out_data=0xFFFF_FFFF_8000_0001, out_tag=7, out_valid=1 for exactly one cycle.
- All modes on input 0x1234_5678_9ABC_DEF0:
  - 000 → 0x1234_5678_9ABC_DEF0.
  - 001 → 0xFFFF_FFFF_FFFF_FFF0.
  - 010 → 0xFFFF_FFFF_FFFF_DEF0.
  - 011 → 0xFFFF_FFFF_9ABC_DEF0.
  - 100 → 0.
  - 101 → 0xF0.
  - 110 → 0xDEF0.
  - 111 → 0x9ABC_DEF0.
- Backpressure: hold out_ready=0 and push tags 1,2,3 on consecutive cycles → occupancy reaches 2 and in_ready=0, so tag 3 is held off. Then raise out_ready → outputs appear in order 1,2,3, and no beat is lost or duplicated.
- Simultaneous push/pop at occupancy 1: push tag 5 while popping tag 4 → occupancy stays 1 and the next head is tag 5.
- Flush: with occupancy 2, assert flush_i together with in_valid=1 → next cycle occupancy=0, out_valid=0, and the flushed-cycle beat never appears at the output.
- Async reset mid-stream: assert rst between edges while occupancy=2 → out_valid=0, in_ready=1 and occupancy=0 immediately. After release, a fresh push (mode 101, data 0xFF) gives out_data=0xFF.

Source files
------------

// File: rtl/ex_extgen_pkg.sv
// Shared definitions for the EX-stage result extension unit: mode codes,
// default datapath width and the zero-dword constant.
package ex_extgen_pkg;

  localparam int unsigned EXT_MODE_W         = 3;
  localparam int unsigned EXT_DATA_W_DEFAULT = 64;
  localparam int unsigned EXT_OCC_W          = 2;

  localparam logic [63:0] EXT_ZERO_DWORD = 64'h0;

  localparam logic [EXT_MODE_W-1:0] EXT_MODE_PASS = 3'b000;
  localparam logic [EXT_MODE_W-1:0] EXT_MODE_SB   = 3'b001;
  localparam logic [EXT_MODE_W-1:0] EXT_MODE_SH   = 3'b010;
  localparam logic [EXT_MODE_W-1:0] EXT_MODE_SW   = 3'b011;
  localparam logic [EXT_MODE_W-1:0] EXT_MODE_ZERO = 3'b100;
  localparam logic [EXT_MODE_W-1:0] EXT_MODE_ZB   = 3'b101;
  localparam logic [EXT_MODE_W-1:0] EXT_MODE_ZH   = 3'b110;
  localparam logic [EXT_MODE_W-1:0] EXT_MODE_ZW   = 3'b111;

endpackage

// File: rtl/ex_extgen_core.sv
// Combinational mode -> extended-data function. On a 32-bit datapath the
// word modes collapse to pass-through.
module ex_extgen_core
  import ex_extgen_pkg::*;
#(
  parameter int unsigned DATA_W = EXT_DATA_W_DEFAULT
) (
  input  logic [EXT_MODE_W-1:0] mode_i,
  input  logic [DATA_W-1:0]     data_i,
  output logic [DATA_W-1:0]     data_o
);

  logic [DATA_W-1:0] sb, sh, sw, zb, zh, zw;

  assign sb = {{(DATA_W-8){data_i[7]}}, data_i[7:0]};
  assign sh = {{(DATA_W-16){data_i[15]}}, data_i[15:0]};
  assign zb = {{(DATA_W-8){1'b0}}, data_i[7:0]};
  assign zh = {{(DATA_W-16){1'b0}}, data_i[15:0]};

  // Word extension only exists when there are bits above 31
  if (DATA_W > 32) begin : g_word_ext
    assign sw = {{(DATA_W-32){data_i[31]}}, data_i[31:0]};
    assign zw = {{(DATA_W-32){1'b0}}, data_i[31:0]};
  end else begin : g_word_pass
    assign sw = data_i;
    assign zw = data_i;
  end

  always_comb begin
    data_o = '0;
    case (mode_i)
      EXT_MODE_PASS: data_o = data_i;
      EXT_MODE_SB:   data_o = sb;
      EXT_MODE_SH:   data_o = sh;
      EXT_MODE_SW:   data_o = sw;
      EXT_MODE_ZERO: data_o = '0;
      EXT_MODE_ZB:   data_o = zb;
      EXT_MODE_ZH:   data_o = zh;
      EXT_MODE_ZW:   data_o = zw;
      default:       data_o = '0;
    endcase
  end

endmodule

// File: rtl/ex_extgen_pipe.sv
// EX-stage result extension unit: extends the incoming value by mode and
// buffers extended data plus tag in a 2-entry skid FIFO toward MEM.
module ex_extgen_pipe
  import ex_extgen_pkg::*;
#(
  parameter int unsigned DATA_W = EXT_DATA_W_DEFAULT,
  parameter int unsigned TAG_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [EXT_MODE_W-1:0] in_mode_i,
  input  logic [DATA_W-1:0]     in_data_i,
  input  logic [TAG_W-1:0]      in_tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_W-1:0]     out_data_o,
  output logic [TAG_W-1:0]      out_tag_o,
  output logic [EXT_OCC_W-1:0]  occupancy_o
);

  localparam logic [EXT_OCC_W-1:0] OCC_FULL  = EXT_OCC_W'(2);
  localparam logic [EXT_OCC_W-1:0] OCC_EMPTY = EXT_OCC_W'(0);

  logic [DATA_W-1:0]    ext_data;
  logic [DATA_W-1:0]    data_q [2];
  logic [DATA_W-1:0]    data_d [2];
  logic [TAG_W-1:0]     tag_q  [2];
  logic [TAG_W-1:0]     tag_d  [2];
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic [EXT_OCC_W-1:0] occ_q, occ_d;
  logic                 push, pop;

  ex_extgen_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .mode_i (in_mode_i),
    .data_i (in_data_i),
    .data_o (ext_data)
  );

  // Handshake status decoded from the occupancy register only
  assign in_ready_o  = (occ_q != OCC_FULL);
  assign out_valid_o = (occ_q != OCC_EMPTY);
  assign occupancy_o = occ_q;
  assign out_data_o  = data_q[rd_ptr_q];
  assign out_tag_o   = tag_q[rd_ptr_q];

  assign push = in_valid_i && in_ready_o && !flush_i;
  assign pop  = out_valid_o && out_ready_i && !flush_i;

  always_comb begin
    data_d   = data_q;
    tag_d    = tag_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      occ_d    = OCC_EMPTY;
    end else begin
      if (push) begin
        data_d[wr_ptr_q] = ext_data;
        tag_d[wr_ptr_q]  = in_tag_i;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      occ_d = occ_q + EXT_OCC_W'(push) - EXT_OCC_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q[0] <= DATA_W'(EXT_ZERO_DWORD);
      data_q[1] <= DATA_W'(EXT_ZERO_DWORD);
      tag_q[0]  <= '0;
      tag_q[1]  <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      occ_q     <= OCC_EMPTY;
    end else begin
      data_q    <= data_d;
      tag_q     <= tag_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      occ_q     <= occ_d;
    end
  end

endmodule

// File: tb/tb_ex_extgen_pipe.sv
// Self-checking bench for ex_extgen_pipe (DATA_W=64) against a queue-based
// reference model with arithmetic extension.
module tb_ex_extgen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [2:0]  in_mode_i = 3'd0;
  logic [63:0] in_data_i = 64'd0;
  logic [4:0]  in_tag_i = 5'd0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [63:0] out_data_o;
  logic [4:0]  out_tag_o;
  logic [1:0]  occupancy_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] d;
    logic [4:0]  t;
  } ent_t;

  ent_t       mq[$];
  logic [4:0] popped[$];

  always #5 clk = ~clk;

  ex_extgen_pipe #(.DATA_W(64), .TAG_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_mode_i   (in_mode_i),
    .in_data_i   (in_data_i),
    .in_tag_i    (in_tag_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_tag_o   (out_tag_o),
    .occupancy_o (occupancy_o)
  );

  // Keep the low n bits, then reinterpret as signed for the sign modes
  function automatic logic [63:0] ref_ext(input logic [2:0] m, input logic [63:0] d);
    int unsigned n;
    logic [63:0] lim, v;
    case (m[1:0])
      2'd0:    return m[2] ? 64'd0 : d;
      2'd1:    n = 8;
      2'd2:    n = 16;
      default: n = 32;
    endcase
    lim = 64'd1 << n;
    v = d % lim;
    if (!m[2] && v >= (lim >> 1)) v = v - lim;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check state against the model, drive, advance, update model
  task automatic cycle(input logic v, input logic [2:0] m, input logic [63:0] d,
                       input logic [4:0] t, input logic ordy, input logic fl);
    bit mpush, mpop;
    ent_t e;
    in_valid_i  = v;
    in_mode_i   = m;
    in_data_i   = d;
    in_tag_i    = t;
    out_ready_i = ordy;
    flush_i     = fl;
    chk("in_ready", 64'(in_ready_o), 64'(mq.size() != 2));
    chk("out_valid", 64'(out_valid_o), 64'(mq.size() != 0));
    chk("occupancy", 64'(occupancy_o), 64'(mq.size()));
    if (mq.size() != 0) begin
      chk("head_data", out_data_o, mq[0].d);
      chk("head_tag", 64'(out_tag_o), 64'(mq[0].t));
    end
    mpush = v && (mq.size() != 2) && !fl;
    mpop  = (mq.size() != 0) && ordy && !fl;
    if (mpop) popped.push_back(out_tag_o);
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (mpop) void'(mq.pop_front());
      if (mpush) begin
        e.d = ref_ext(m, d);
        e.t = t;
        mq.push_back(e);
      end
    end
    #1;
  endtask

  logic [63:0] tbl [8];

  initial begin
    tbl[0] = 64'h1234_5678_9ABC_DEF0;
    tbl[1] = 64'hFFFF_FFFF_FFFF_FFF0;
    tbl[2] = 64'hFFFF_FFFF_FFFF_DEF0;
    tbl[3] = 64'hFFFF_FFFF_9ABC_DEF0;
    tbl[4] = 64'h0;
    tbl[5] = 64'hF0;
    tbl[6] = 64'hDEF0;
    tbl[7] = 64'h9ABC_DEF0;

    // Reset state while rst is held
    #2;
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_ready", 64'(in_ready_o), 64'd1);
    chk("rst_occ", 64'(occupancy_o), 64'd0);
    chk("rst_data", out_data_o, 64'd0);
    chk("rst_tag", 64'(out_tag_o), 64'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // SW sign-extend, consumer ready, valid for exactly one cycle
    cycle(1, 3'b011, 64'h0000_0000_8000_0001, 5'd7, 1, 0);
    chk("sw_data", out_data_o, 64'hFFFF_FFFF_8000_0001);
    chk("sw_tag", 64'(out_tag_o), 64'd7);
    chk("sw_valid", 64'(out_valid_o), 64'd1);
    cycle(0, 3'd0, 64'd0, 5'd0, 1, 0);
    chk("sw_valid_once", 64'(out_valid_o), 64'd0);

    // Every mode on the reference pattern
    for (int i = 0; i < 8; i++) begin
      cycle(1, 3'(i), 64'h1234_5678_9ABC_DEF0, 5'(i), 1, 0);
      chk($sformatf("mode%0d", i), out_data_o, tbl[i]);
    end
    cycle(0, 3'd0, 64'd0, 5'd0, 1, 0);

    // Backpressure: tags 1,2,3 with a stalled consumer
    popped.delete();
    cycle(1, 3'd0, 64'h11, 5'd1, 0, 0);
    cycle(1, 3'd0, 64'h22, 5'd2, 0, 0);
    chk("bp_occ_full", 64'(occupancy_o), 64'd2);
    chk("bp_ready_low", 64'(in_ready_o), 64'd0);
    cycle(1, 3'd0, 64'h33, 5'd3, 0, 0);
    chk("bp_held_off", 64'(occupancy_o), 64'd2);
    cycle(1, 3'd0, 64'h33, 5'd3, 1, 0);
    cycle(1, 3'd0, 64'h33, 5'd3, 1, 0);
    cycle(0, 3'd0, 64'd0, 5'd0, 1, 0);
    cycle(0, 3'd0, 64'd0, 5'd0, 1, 0);
    chk("bp_count", 64'(popped.size()), 64'd3);
    for (int i = 0; i < 3 && i < popped.size(); i++)
      chk($sformatf("bp_order%0d", i), 64'(popped[i]), 64'(i + 1));

    // Simultaneous push and pop at occupancy 1
    cycle(1, 3'd0, 64'h44, 5'd4, 0, 0);
    cycle(1, 3'd0, 64'h55, 5'd5, 1, 0);
    chk("pp_occ", 64'(occupancy_o), 64'd1);
    chk("pp_head", 64'(out_tag_o), 64'd5);
    cycle(0, 3'd0, 64'd0, 5'd0, 1, 0);

    // Flush while full with a beat presented
    cycle(1, 3'd0, 64'h66, 5'd6, 0, 0);
    cycle(1, 3'd0, 64'h77, 5'd7, 0, 0);
    cycle(1, 3'd0, 64'h99, 5'd9, 1, 1);
    chk("fl_occ", 64'(occupancy_o), 64'd0);
    chk("fl_valid", 64'(out_valid_o), 64'd0);
    cycle(0, 3'd0, 64'd0, 5'd0, 1, 0);
    cycle(0, 3'd0, 64'd0, 5'd0, 1, 0);

    // Async reset between edges while full
    cycle(1, 3'd0, 64'hA1, 5'd10, 0, 0);
    cycle(1, 3'd0, 64'hA2, 5'd11, 0, 0);
    in_valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 64'(out_valid_o), 64'd0);
    chk("ar_ready", 64'(in_ready_o), 64'd1);
    chk("ar_occ", 64'(occupancy_o), 64'd0);
    mq.delete();
    #2 rst = 1'b0;
    @(posedge clk); #1;
    cycle(1, 3'b101, 64'hFF, 5'd3, 1, 0);
    chk("ar_zb", out_data_o, 64'hFF);
    cycle(0, 3'd0, 64'd0, 5'd0, 1, 0);

    // Randomized traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom), 3'($urandom), {$urandom, $urandom}, 5'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
    end
    for (int i = 0; i < 3; i++) cycle(0, 3'd0, 64'd0, 5'd0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
